// File: rtl/logo_motion_sched.sv
// Bouncing-logo motion scheduler: frame-tick divider, X/Y step FSM with bounce, sound req/ack.
// Optional macro LOGO_SCHED_CORNER_EN: a simultaneous X+Y bounce reports code 11 instead of 10.
module logo_motion_sched #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int W_LOGO     = 80,
   parameter int H_LOGO     = 96,
   parameter int INC_X      = 1,
   parameter int INC_Y      = 2,
   parameter int DELAY_INIT = 2,
   parameter int DELAY_MAX  = 15
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       inc_vel,
   input  logic       dec_vel,
   input  logic       snd_ack,
   output logic [9:0] x_logo,
   output logic [9:0] y_logo,
   output logic       step_done,
   output logic       snd_req,
   output logic [1:0] snd_code,
   output logic       mute
);
   localparam logic [9:0] X_MAX    = 10'(SCREEN_W - W_LOGO);
   localparam logic [9:0] Y_MAX    = 10'(SCREEN_H - H_LOGO);
   localparam logic [9:0] X_RST    = 10'((SCREEN_W - W_LOGO) / 2);
   localparam logic [9:0] Y_RST    = 10'((SCREEN_H - H_LOGO) / 2);
   localparam logic [3:0] MAG_X    = 4'(INC_X);
   localparam logic [3:0] MAG_Y    = 4'(INC_Y);
   localparam logic [5:0] DLY_INIT = 6'(DELAY_INIT);
   localparam logic [5:0] DLY_MAX  = 6'(DELAY_MAX);

   typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, REPORT} state_t;

   state_t     state_q, state_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
   logic       bx_q, bx_d, by_q, by_d;
   logic [5:0] delay_q, delay_d, cnt_q, cnt_d;
   logic       inc_prev_q, dec_prev_q;
   logic       req_q, req_d;
   logic [1:0] code_q, code_d;
   logic       done_q, done_d;
   logic       mute_q;
   logic       inc_rise, dec_rise;

   // Returns {bounced, new_dir_negative, new_pos}; 11-bit signed math keeps pos-mag below 0 visible.
   function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic neg,
                                             input logic [3:0] mag, input logic [9:0] lim);
      logic signed [10:0] nxt;
      logic signed [10:0] lim_s;
      lim_s = $signed({1'b0, lim});
      if (neg) nxt = $signed({1'b0, pos}) - $signed({7'b0, mag});
      else     nxt = $signed({1'b0, pos}) + $signed({7'b0, mag});
      if (nxt >= lim_s)       return {1'b1, 1'b1, lim};
      else if (nxt <= 11'sd0) return {1'b1, 1'b0, 10'd0};
      else                    return {1'b0, neg, nxt[9:0]};
   endfunction

   assign inc_rise = inc_vel & ~inc_prev_q;
   assign dec_rise = dec_vel & ~dec_prev_q;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_neg_d = dx_neg_q;
      dy_neg_d = dy_neg_q;
      bx_d     = bx_q;
      by_d     = by_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      code_d   = code_q;
      done_d   = 1'b0;
      delay_d  = delay_q;

      if (inc_rise && !dec_rise && delay_q < DLY_MAX)
         delay_d = delay_q + 6'd1;
      else if (dec_rise && !inc_rise && delay_q != '0)
         delay_d = delay_q - 6'd1;

      if (req_q && snd_ack)
         req_d = 1'b0;

      case (state_q)
         IDLE: begin
            // >= so a counter left above a freshly decremented delay still fires next tick
            if (frame_tick && enable) begin
               if (cnt_q >= delay_q) begin
                  cnt_d   = '0;
                  state_d = MOVE_X;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         MOVE_X: begin
            {bx_d, dx_neg_d, x_d} = axis_step(x_q, dx_neg_q, MAG_X, X_MAX);
            state_d = MOVE_Y;
         end
         MOVE_Y: begin
            {by_d, dy_neg_d, y_d} = axis_step(y_q, dy_neg_q, MAG_Y, Y_MAX);
            state_d = REPORT;
         end
         REPORT: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if ((bx_q || by_q) && !req_q) begin
               req_d = 1'b1;
`ifdef LOGO_SCHED_CORNER_EN
               if (bx_q && by_q) code_d = 2'b11;
               else if (by_q)    code_d = 2'b10;
               else              code_d = 2'b01;
`else
               if (by_q) code_d = 2'b10;
               else      code_d = 2'b01;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= IDLE;
         x_q        <= X_RST;
         y_q        <= Y_RST;
         dx_neg_q   <= 1'b0;
         dy_neg_q   <= 1'b0;
         bx_q       <= 1'b0;
         by_q       <= 1'b0;
         delay_q    <= DLY_INIT;
         cnt_q      <= '0;
         inc_prev_q <= 1'b0;
         dec_prev_q <= 1'b0;
         req_q      <= 1'b0;
         code_q     <= '0;
         done_q     <= 1'b0;
         mute_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dx_neg_q   <= dx_neg_d;
         dy_neg_q   <= dy_neg_d;
         bx_q       <= bx_d;
         by_q       <= by_d;
         delay_q    <= delay_d;
         cnt_q      <= cnt_d;
         inc_prev_q <= inc_vel;
         dec_prev_q <= dec_vel;
         req_q      <= req_d;
         code_q     <= code_d;
         done_q     <= done_d;
         mute_q     <= ~enable;
      end
   end

   assign x_logo    = x_q;
   assign y_logo    = y_q;
   assign step_done = done_q;
   assign snd_req   = req_q;
   assign snd_code  = code_q;
   assign mute      = mute_q;
endmodule

// File: tb/tb_logo_motion_sched.sv
// Self-checking bench for logo_motion_sched: vector table, hand sequences, random ops vs a step-level model.
module tb_logo_motion_sched;
   logic       clk = 1'b0;
   logic       clr, frame_tick, enable, inc_vel, dec_vel, snd_ack;
   logic [9:0] x_logo, y_logo;
   logic       step_done, snd_req, mute;
   logic [1:0] snd_code;

   logic       clr_c, tick_c, en_c, zero_c;
   logic [9:0] x_c, y_c;
   logic       done_c, req_c, mute_c;
   logic [1:0] code_c;

   always #5 clk = ~clk;

   logo_motion_sched dut (
      .clk(clk), .clr(clr), .frame_tick(frame_tick), .enable(enable),
      .inc_vel(inc_vel), .dec_vel(dec_vel), .snd_ack(snd_ack),
      .x_logo(x_logo), .y_logo(y_logo), .step_done(step_done),
      .snd_req(snd_req), .snd_code(snd_code), .mute(mute));

   logo_motion_sched #(
      .SCREEN_W(480), .SCREEN_H(480), .W_LOGO(96), .H_LOGO(96),
      .INC_X(1), .INC_Y(1), .DELAY_INIT(0), .DELAY_MAX(15)
   ) dut_c (
      .clk(clk), .clr(clr_c), .frame_tick(tick_c), .enable(en_c),
      .inc_vel(zero_c), .dec_vel(zero_c), .snd_ack(zero_c),
      .x_logo(x_c), .y_logo(y_c), .step_done(done_c),
      .snd_req(req_c), .snd_code(code_c), .mute(mute_c));

`ifdef LOGO_SCHED_CORNER_EN
   localparam bit CORNER = 1'b1;
`else
   localparam bit CORNER = 1'b0;
`endif
   localparam int XMAX = 560;
   localparam int YMAX = 384;

   int n_tests = 0;
   int n_fail  = 0;
   int sd_cnt  = 0;
   int sdc_cnt = 0;

   // step-level reference model
   int mx, my, mdx, mdy, mdel, mcnt, mcode, msteps;
   bit mreq, men;

   always @(negedge clk) begin
      if (step_done === 1'b1) sd_cnt++;
      if (done_c === 1'b1) sdc_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mx = 280; my = 192; mdx = 1; mdy = 2; mdel = 2; mcnt = 0; mreq = 0; mcode = 0;
   endtask

   task automatic model_step();
      int nx, ny;
      bit bx, by;
      bx = 0; by = 0;
      nx = mx + mdx;
      if (nx >= XMAX)   begin mx = XMAX; mdx = -((mdx < 0) ? -mdx : mdx); bx = 1; end
      else if (nx <= 0) begin mx = 0;    mdx =  ((mdx < 0) ? -mdx : mdx); bx = 1; end
      else mx = nx;
      ny = my + mdy;
      if (ny >= YMAX)   begin my = YMAX; mdy = -((mdy < 0) ? -mdy : mdy); by = 1; end
      else if (ny <= 0) begin my = 0;    mdy =  ((mdy < 0) ? -mdy : mdy); by = 1; end
      else my = ny;
      msteps++;
      if ((bx || by) && !mreq) begin
         mreq  = 1;
         mcode = by ? ((bx && CORNER) ? 3 : 2) : 1;
      end
   endtask

   task automatic model_tick();
      if (!men) return;
      if (mcnt >= mdel) begin mcnt = 0; model_step(); end
      else mcnt++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".x"}, 32'(x_logo), 32'(mx));
      chk({tag, ".y"}, 32'(y_logo), 32'(my));
      chk({tag, ".req"}, 32'(snd_req), 32'(mreq));
      chk({tag, ".code"}, 32'(snd_code), 32'(mcode));
      chk({tag, ".steps"}, 32'(sd_cnt), 32'(msteps));
      chk({tag, ".mute"}, 32'(mute), 32'(!men));
   endtask

   task automatic do_tick();
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      model_tick();
   endtask

   task automatic pulse_vel(input bit inc, input bit dec);
      @(negedge clk); inc_vel = inc; dec_vel = dec;
      @(negedge clk); inc_vel = 1'b0; dec_vel = 1'b0;
      @(negedge clk);
      if (inc && !dec && mdel < 15) mdel++;
      else if (dec && !inc && mdel > 0) mdel--;
   endtask

   task automatic do_ack();
      @(negedge clk); snd_ack = 1'b1;
      @(negedge clk); snd_ack = 1'b0;
      @(negedge clk);
      mreq = 0;
   endtask

   task automatic set_en(input bit b);
      @(negedge clk); enable = b; men = b;
      @(negedge clk);
   endtask

   typedef struct {
      bit en;
      int x;
      int y;
      int steps;
   } vec_t;

   vec_t vt[10];

   initial begin
      int base, old_y;
      vt[0] = '{1'b1, 280, 192, 0};
      vt[1] = '{1'b1, 280, 192, 0};
      vt[2] = '{1'b1, 281, 194, 1};
      vt[3] = '{1'b1, 281, 194, 1};
      vt[4] = '{1'b1, 281, 194, 1};
      vt[5] = '{1'b1, 282, 196, 2};
      vt[6] = '{1'b1, 282, 196, 2};
      vt[7] = '{1'b1, 282, 196, 2};
      vt[8] = '{1'b1, 283, 198, 3};
      vt[9] = '{1'b0, 283, 198, 3};

      clr = 1'b1; frame_tick = 1'b0; enable = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0; snd_ack = 1'b0;
      clr_c = 1'b1; tick_c = 1'b0; en_c = 1'b1; zero_c = 1'b0;
      men = 0; msteps = 0; model_reset();

      // reset state
      #12;
      chk("rst.x", 32'(x_logo), 280);
      chk("rst.y", 32'(y_logo), 192);
      chk("rst.req", 32'(snd_req), 0);
      chk("rst.code", 32'(snd_code), 0);
      chk("rst.done", 32'(step_done), 0);
      chk("rst.mute", 32'(mute), 1);
      @(negedge clk); clr = 1'b0; clr_c = 1'b0;
      set_en(1'b1);
      chk("mute_lag", 32'(mute), 0);

      // vector table: ticks with DELAY_INIT=2
      base = sd_cnt;
      for (int i = 0; i < 10; i++) begin
         set_en(vt[i].en);
         do_tick();
         chk($sformatf("vec%0d.x", i), 32'(x_logo), 32'(vt[i].x));
         chk($sformatf("vec%0d.y", i), 32'(y_logo), 32'(vt[i].y));
         chk($sformatf("vec%0d.steps", i), 32'(sd_cnt - base), 32'(vt[i].steps));
         check_model($sformatf("vec%0d", i));
      end
      set_en(1'b1);

      // delay down to 0, then dec at 0 and inc+dec together leave it at 0
      pulse_vel(0, 1); pulse_vel(0, 1); pulse_vel(0, 1); pulse_vel(1, 1);
      base = sd_cnt;
      do_tick(); do_tick();
      chk("delay0.steps", 32'(sd_cnt - base), 2);
      check_model("delay0");

      // step latency: x after E1, y after E2, step_done after E3
      old_y = my;
      model_tick();
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      chk("lat.x_e0", 32'(x_logo), 32'(mx - mdx));
      @(negedge clk);
      chk("lat.x_e1", 32'(x_logo), 32'(mx));
      chk("lat.y_e1", 32'(y_logo), 32'(old_y));
      @(negedge clk);
      chk("lat.y_e2", 32'(y_logo), 32'(my));
      chk("lat.done_e2", 32'(step_done), 0);
      @(negedge clk);
      chk("lat.done_e3", 32'(step_done), 1);
      @(negedge clk);
      chk("lat.done_pulse", 32'(step_done), 0);
      check_model("lat");

      // tick held into MOVE_X is ignored
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk);
      @(negedge clk); frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      model_tick();
      check_model("busy_tick");

      // disable mid-step: step still completes
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0; enable = 1'b0;
      repeat (4) @(negedge clk);
      model_tick(); men = 0;
      check_model("en_mid");
      base = sd_cnt;
      do_tick();
      chk("en_off.steps", 32'(sd_cnt - base), 0);
      set_en(1'b1);

      // Y bounce at step 96
      while (msteps < 96) do_tick();
      chk("ybounce.y", 32'(y_logo), 384);
      chk("ybounce.x", 32'(x_logo), 376);
      chk("ybounce.req", 32'(snd_req), 1);
      chk("ybounce.code", 32'(snd_code), 2);
      do_tick();
      chk("after_ybounce.y", 32'(y_logo), 382);

      // X bounce at step 280 while ping still pending: pong dropped
      while (msteps < 280) do_tick();
      chk("xbounce.x", 32'(x_logo), 560);
      chk("xbounce.req", 32'(snd_req), 1);
      chk("xbounce.code", 32'(snd_code), 2);
      check_model("xbounce");
      @(negedge clk); snd_ack = 1'b1;
      chk("ack.req_before", 32'(snd_req), 1);
      @(negedge clk); snd_ack = 1'b0;
      chk("ack.req_after", 32'(snd_req), 0);
      chk("ack.code_hold", 32'(snd_code), 2);
      mreq = 0;

      // saturate delay at 15: 15 ticks no step, 16th steps
      for (int i = 0; i < 20; i++) pulse_vel(1, 0);
      base = sd_cnt;
      for (int i = 0; i < 15; i++) do_tick();
      chk("sat.no_step", 32'(sd_cnt - base), 0);
      do_tick();
      chk("sat.step", 32'(sd_cnt - base), 1);
      check_model("sat");
      for (int i = 0; i < 15; i++) pulse_vel(0, 1);

      // randomized operations against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 60)      do_tick();
         else if (r < 65) pulse_vel(1, 0);
         else if (r < 73) pulse_vel(0, 1);
         else if (r < 76) pulse_vel(1, 1);
         else if (r < 88) do_ack();
         else             set_en(($urandom_range(0, 3) != 0));
         check_model($sformatf("rnd%0d", i));
      end
      set_en(1'b1);

      // clr between E1 and E2 aborts the step asynchronously
      while (mcnt < mdel) do_tick();
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(posedge clk); #2;
      clr = 1'b1;
      #1;
      chk("clr.x", 32'(x_logo), 280);
      chk("clr.y", 32'(y_logo), 192);
      chk("clr.req", 32'(snd_req), 0);
      chk("clr.mute", 32'(mute), 1);
      repeat (2) @(negedge clk);
      clr = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      sd_cnt = msteps;
      do_tick(); do_tick(); do_tick();
      chk("post_clr.x", 32'(x_logo), 281);
      chk("post_clr.y", 32'(y_logo), 194);
      check_model("post_clr");

      // corner instance: 192 steps reach (384,384) in both axes at once
      for (int i = 0; i < 192; i++) begin
         @(negedge clk); tick_c = 1'b1;
         @(negedge clk); tick_c = 1'b0;
         repeat (4) @(negedge clk);
         if (i == 190) chk("corner.req_early", 32'(req_c), 0);
      end
      chk("corner.x", 32'(x_c), 384);
      chk("corner.y", 32'(y_c), 384);
      chk("corner.req", 32'(req_c), 1);
      chk("corner.code", 32'(code_c), CORNER ? 3 : 2);
      chk("corner.steps", 32'(sdc_cnt), 192);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
